// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: in-order valid/ready front-end for the dual-port ram block.
// Absorbs the one-cycle RAM read latency in a 2-entry response FIFO.
// Optional macro RAM_ACCESS_CTRL_INIT_EN compiles in a zero-fill sweep after reset.
module ram_access_ctrl #(
  parameter int unsigned add_size  = 11,
  parameter int unsigned data_size = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [add_size-1:0]  req_addr,
  input  logic [data_size-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [data_size-1:0] rsp_data,
  output logic                 init_done,
  output logic                 ram_write_en,
  output logic [add_size-1:0]  ram_write_address,
  output logic [data_size-1:0] ram_data_in,
  output logic                 ram_read_en,
  output logic [add_size-1:0]  ram_read_address,
  input  logic [data_size-1:0] ram_data_out
);

`ifdef RAM_ACCESS_CTRL_INIT_EN
  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
  localparam logic [add_size-1:0] CNT_MAX = {add_size{1'b1}};
  logic [add_size-1:0] init_cnt;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t                 state, state_nxt;
  logic                   inflight;
  logic [1:0]             count;
  logic                   head;
  logic [data_size-1:0]   fifo_mem [2];
  logic [1:0]             occ;
  logic                   pop;
  logic                   push;
  logic                   tail;

  assign rsp_valid = (count != 2'd0);
  assign rsp_data  = fifo_mem[head];
  assign init_done = (state == RUN);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = inflight;
  assign occ       = count + 2'(inflight);
  assign tail      = head ^ count[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, request handshake and RAM port drive
  always_comb begin
    state_nxt         = state;
    req_ready         = 1'b0;
    ram_write_en      = 1'b0;
    ram_write_address = req_addr;
    ram_data_in       = req_wdata;
    ram_read_en       = 1'b0;
    ram_read_address  = req_addr;
    case (state)
`ifdef RAM_ACCESS_CTRL_INIT_EN
      IDLE: state_nxt = INIT;
      INIT: begin
        ram_write_en      = 1'b1;
        ram_write_address = init_cnt;
        ram_data_in       = '0;
        if (init_cnt == CNT_MAX) state_nxt = RUN;
      end
`else
      IDLE: state_nxt = RUN;
`endif
      RUN: begin
        req_ready    = (occ < 2'd2) | pop;
        ram_write_en = req_valid & req_ready & req_write;
        ram_read_en  = req_valid & req_ready & ~req_write;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RAM_ACCESS_CTRL_INIT_EN
  // Sweep address counter, saturates at the last word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  init_cnt <= '0;
    else if (state == INIT && init_cnt != CNT_MAX) init_cnt <= init_cnt + add_size'(1);
  end
`endif

  // In-flight read flag: set on read issue, cleared when data is captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= ram_read_en;
  end

  // Response FIFO pointers and storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 2'd0;
      head        <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (push) fifo_mem[tail] <= ram_data_out;
      if (pop)  head <= ~head;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 1-cycle-latency RAM.
module tb_ram_access_ctrl;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          init_done;
  logic          ram_write_en, ram_read_en;
  logic [AW-1:0] ram_write_address, ram_read_address;
  logic [DW-1:0] ram_data_in, ram_data_out;
  logic [DW-1:0] ram [16];

  int vectors = 0;
  int miscompares = 0;

  ram_access_ctrl #(.add_size(AW), .data_size(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done),
    .ram_write_en(ram_write_en), .ram_write_address(ram_write_address),
    .ram_data_in(ram_data_in), .ram_read_en(ram_read_en),
    .ram_read_address(ram_read_address), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM
  always_ff @(posedge clk) begin
    if (ram_write_en) ram[ram_write_address] <= ram_data_in;
    if (ram_read_en)  ram_data_out <= ram[ram_read_address];
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
`ifdef RAM_ACCESS_CTRL_INIT_EN
    for (int i = 0; i < 16; i++) begin
      check("sweep_we", 32'(ram_write_en), 32'd1);
      check("sweep_addr", 32'(ram_write_address), 32'(i));
      check("sweep_data", ram_data_in, 32'd0);
      check("sweep_ready", 32'(req_ready), 32'd0);
      step();
    end
`endif
    check("init_done", 32'(init_done), 32'd1);
    check("ready_after_init", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_we", 32'(ram_write_en), 32'd0);
    check("rst_re", 32'(ram_read_en), 32'd0);
    step();
    release_reset();

    // Write then read the same address on the next cycle
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd5; req_wdata = 32'hDEADBEEF;
    #1;
    check("wr_we", 32'(ram_write_en), 32'd1);
    check("wr_addr", 32'(ram_write_address), 32'd5);
    step();
    req_write = 1'b0;
    #1;
    check("rd_re", 32'(ram_read_en), 32'd1);
    check("rd_we_low", 32'(ram_write_en), 32'd0);
    step();
    req_valid = 1'b0;
    check("rd_not_yet", 32'(rsp_valid), 32'd0);
    step();
    check("rd_valid", 32'(rsp_valid), 32'd1);
    check("rd_data", rsp_data, 32'hDEADBEEF);
    step();
    check("rd_drained", 32'(rsp_valid), 32'd0);

    // Preload 0..7 with 0x100+i
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 4'(i); req_wdata = 32'h100 + 32'(i);
      step();
    end
    req_write = 1'b0;

    // Back-to-back reads of 0..7
    for (int i = 0; i < 9; i++) begin
      req_valid = (i < 8); req_addr = 4'(i);
      #1;
      if (i < 8) check("stream_ready", 32'(req_ready), 32'd1);
      step();
      if (i >= 1) begin
        check("stream_valid", 32'(rsp_valid), 32'd1);
        check("stream_data", rsp_data, 32'h100 + 32'(i - 1));
      end
    end
    step();
    check("stream_empty", 32'(rsp_valid), 32'd0);

    // Backpressure: two reads fill occupancy, third stalls
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 4'd1;
    step();
    req_addr = 4'd2;
    #1;
    check("bp_ready2", 32'(req_ready), 32'd1);
    step();
    req_addr = 4'd3;
    #1;
    check("bp_stall", 32'(req_ready), 32'd0);
    step();
    check("bp_stall_hold", 32'(req_ready), 32'd0);
    check("bp_hold_valid", 32'(rsp_valid), 32'd1);
    check("bp_hold_data", rsp_data, 32'h101);
    rsp_ready = 1'b1;
    #1;
    check("bp_ready_on_pop", 32'(req_ready), 32'd1);
    check("bp_re_on_pop", 32'(ram_read_en), 32'd1);
    step();
    req_valid = 1'b0;
    check("bp_data2", rsp_data, 32'h102);
    step();
    check("bp_valid3", 32'(rsp_valid), 32'd1);
    check("bp_data3", rsp_data, 32'h103);
    step();
    check("bp_empty", 32'(rsp_valid), 32'd0);

    // Reset with two reads outstanding
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 4'd4;
    step();
    req_addr = 4'd5;
    step();
    req_valid = 1'b0;
    check("mid_valid_pre", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_done", 32'(init_done), 32'd0);
    rsp_ready = 1'b1;
    release_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_stale", 32'(rsp_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Request/response front-end that drives the write and read ports of the team's dual-port `ram` block. It accepts a single valid/ready request stream of reads and writes and issues them in order to the RAM. It absorbs the RAM's one-cycle read latency in a 2-entry response buffer and returns read data on a valid/ready response channel. An optional zero-fill sweep runs after reset, since the RAM has no usable reset of its own.

## Interface
- `add_size`, 11: RAM address width; the RAM holds 2^add_size words.
- `data_size`, 32: data word width.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid` at an edge.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  add_size  request address.
- `req_wdata`  in  data_size  write data (ignored for reads).
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_data`  out  data_size  read data.
- `init_done`  out  1  high once the block is in RUN.
- `ram_write_en`  out  1  to RAM `write_en`.
- `ram_write_address`  out  add_size  to RAM `write_address`.
- `ram_data_in`  out  data_size  to RAM `data_in`.
- `ram_read_en`  out  1  to RAM `read_en`.
- `ram_read_address`  out  add_size  to RAM `read_address`.
- `ram_data_out`  in  data_size  from RAM `data_out`; valid one edge after `ram_read_en`.

## Operation
- **FSM states:**
  - IDLE is the reset state.
  - IDLE→INIT at the first edge after reset release, with the macro defined.
  - IDLE→RUN at that edge, without the macro.
  - INIT→RUN on the edge that writes the last address.
- **INIT:**
  - `init_cnt` (add_size bits) runs 0 → 2^add_size−1.
  - Each cycle drives `ram_write_en`=1, `ram_write_address`=`init_cnt`, `ram_data_in`=0.
  - `req_ready`=0 throughout INIT.
- **RUN, acceptance:**
  - Definitions: `acc` = `req_valid & req_ready`; `pop` = `rsp_valid & rsp_ready`; `occ` = buffered entries + in-flight read (0..2).
  - `req_ready` = (state==RUN) & (`occ`<2 | `pop`). This is combinational from `rsp_ready`, and the path is permitted.
- **RUN, writes:**
  - `ram_write_en` = `acc & req_write`.
  - `ram_write_address`=`req_addr`, `ram_data_in`=`req_wdata` (combinational).
- **RUN, reads:**
  - `ram_read_en` = `acc & ~req_write`, with `ram_read_address`=`req_addr`.
  - Sets the `inflight` flag.
  - On the next edge, `ram_data_out` is pushed into the buffer and `inflight` clears.
- **Response buffer:**
  - 2-entry FIFO; `rsp_data` is the head entry.
  - `rsp_valid` = FIFO non-empty.
  - Push and pop on the same edge are both performed.
- **Ordering:** strict request order. A write accepted at edge N is visible to a read accepted at edge N+1 or later.
- **Outside RUN:** `ram_read_en`=0, and `ram_write_en` is 0 except during INIT.

## Timing
- **Reset values (while `rst_n`=0):**
  - State IDLE; `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `init_done`=0.
  - All RAM enables 0; `init_cnt`=0; `inflight`=0; FIFO empty.
- **Read latency:** accepted at edge E0, RAM samples at E0, captured at E1; `rsp_valid` is high after E1 if the FIFO was empty.
- **Throughput:** one request per cycle sustained while `rsp_ready`=1.
- **Init duration:** 2^add_size cycles of INIT plus one IDLE cycle.
- **Boundary cases:**
  - **`occ`==2 with no pop:** `req_ready`=0 (reads and writes both stall).
  - **Response held, `rsp_ready`=0:** `rsp_data` and `rsp_valid` hold stable until popped.
  - **Reset asserted mid-operation:** FIFO, in-flight read and `init_cnt` are discarded immediately. The sweep restarts from address 0 after release.
  - **`init_cnt` end:** stops at 2^add_size−1 and does not wrap.

## Configuration
- `RAM_ACCESS_CTRL_INIT_EN`:
  - Defined: the INIT zero-fill sweep is compiled in. `init_done` rises when RUN is entered after the sweep.
  - Undefined: INIT state and `init_cnt` are absent. IDLE goes straight to RUN, and `init_done` goes high one edge after reset release. RAM contents are undefined until written.

## Test plan
- **Init sweep** (macro on, add_size=4): release reset → exactly 16 consecutive `ram_write_en` pulses to addresses 0..15 with data 0. `init_done` and `req_ready` rise on the following cycle.
- **Write-then-read:** write 0xDEADBEEF @5, then read @5 next cycle → `rsp_valid` one edge after the read is accepted, `rsp_data`=0xDEADBEEF.
- **Back-to-back streaming:** reads of addresses 0..7 on consecutive cycles with `rsp_ready`=1 → 8 responses in order on consecutive cycles, `req_ready` never low.
- **Backpressure:** `rsp_ready`=0, issue 3 reads → first 2 accepted, `req_ready`=0 for the third. Raise `rsp_ready` → third accepted in the pop cycle, and responses arrive in order.
- **Reset mid-read:** 2 reads outstanding, pulse `rst_n` low for 1 cycle → `rsp_valid`=0 immediately. The sweep restarts at address 0 and no stale responses appear afterwards.
- **Macro off:** release reset → `init_done`=1 after 1 edge, and the first write is accepted on the next cycle.
